hedios_packet_assembler: RTL and testbench
==========================================

Name: hedios_packet_assembler

Overview:
Receive-side framing stage between the UART byte receiver and the Hedios controller. Takes a stream of raw received bytes and finds sync-delimited packets, each carrying an 8-bit command, a 32-bit data word and an XOR checksum. Validated packets are buffered in a first-word-fall-through queue. The queue is drained by the controller through the same pop/command/data/empty/full/lost_data interface the controller already consumes.

Parameters:
QUEUE_DEPTH, 8, packet queue depth in entries; must be a power of 2, minimum 2.
TIMEOUT_CYCLES, 10000, allowed clk cycles between bytes inside a packet before it is abandoned; minimum 1.
SYNC_BYTE, 8'hA5, packet start marker.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
byte_valid  in  1  one-cycle strobe: byte_data holds a newly received byte
byte_data  in  8  received byte
pop_packet  in  1  controller consumes the head entry
packet_command  out  8  head entry command; valid while queue_empty=0
packet_data  out  32  head entry data; valid while queue_empty=0
queue_empty  out  1  queue holds 0 entries
queue_full  out  1  queue holds QUEUE_DEPTH entries
lost_data  out  1  sticky: a valid packet was dropped because the queue was full
clear_errors  in  1  synchronous clear of lost_data
checksum_error  out  1  one-cycle pulse: a packet was dropped on checksum mismatch
timeout_error  out  1  one-cycle pulse: a partial packet was abandoned

Behaviour:
- Packet format on the wire: SYNC_BYTE, CMD, D3, D2, D1, D0, CSUM. Data is MSB first. CSUM = CMD^D3^D2^D1^D0. The sync byte is not part of the checksum.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; queue pointers and count go to 0.
  - queue_empty=1, queue_full=0, lost_data=0, checksum_error=0, timeout_error=0.
  - packet_command=0, packet_data=0.
  - A partially received packet is discarded and no pulse is produced.
- FSM states: IDLE, CMD, D3, D2, D1, D0, CSUM. All transitions happen on byte_valid only, except timeout.
  - IDLE: byte equal to SYNC_BYTE -> CMD. Any other byte is ignored.
  - CMD..D0: latch the byte into the shadow register, update the running XOR, advance to the next state. A SYNC_BYTE value in these states is treated as data.
  - CSUM: byte == running XOR -> push {cmd,data} into the queue; otherwise pulse checksum_error. Either way, go to IDLE.
- Timeout:
  - An idle counter resets to 0 on every accepted byte and counts clk cycles while the FSM is not IDLE.
  - When the counter reaches TIMEOUT_CYCLES without a byte, the FSM goes to IDLE and timeout_error pulses for 1 cycle.
  - If byte_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the timeout wins. The byte is then evaluated as an IDLE byte in that same cycle: if it equals SYNC_BYTE, the FSM goes to CMD.
- Queue:
  - First-word fall-through. Write happens in the cycle the CSUM byte is accepted. The entry is visible on packet_command/packet_data, and queue_empty falls, on the next clk edge (latency 1 cycle from the CSUM strobe).
  - packet_command/packet_data are registered; they hold their last value when the queue is empty.
  - pop_packet while queue_empty=1 is ignored and is not an error.
  - A push while full and without pop: the packet is dropped and lost_data is set. It stays set until clear_errors=1 or reset. If a set and clear_errors coincide, the set wins.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no loss.
  - Push and pop in the same cycle when the queue holds 1 entry: the head updates to the new entry and queue_empty stays 0.
  - Pointers are log2(QUEUE_DEPTH) bits wide and wrap naturally. The count is log2(QUEUE_DEPTH)+1 bits wide.
  - queue_full/queue_empty are registered and reflect the count after each edge.
- checksum_error and timeout_error never assert in the same cycle, because the CSUM evaluation requires a byte, which resets the counter.
- Packets and bytes are never reordered.

Test Plan:
- Good packet: bytes A5 12 DE AD BE EF 30, each 10 cycles apart -> one cycle after the 30 strobe, queue_empty=0, packet_command=0x12, packet_data=0xDEADBEEF. Pulse pop_packet once -> queue_empty=1.
- Bad checksum: A5 12 DE AD BE EF 31 -> checksum_error high for exactly 1 cycle, queue_empty stays 1, FSM accepts the next good packet.
- Timeout: A5 12 DE then silence for TIMEOUT_CYCLES -> timeout_error pulses once. Then the full good packet -> it is queued correctly. Also check that a sync byte landing exactly on the timeout cycle starts a new packet.
- Overflow: QUEUE_DEPTH=8, send 9 good packets with no pops -> queue_full=1 after the 8th, lost_data=1 after the 9th. Popping 8 times yields the first 8 in order. clear_errors -> lost_data=0.
- Full with simultaneous pop and push: fill to 8, assert pop_packet in the CSUM cycle of a 9th packet -> lost_data stays 0, queue_full stays 1, the last entry read is the 9th packet.
- Reset mid-packet: assert rst=0 asynchronously after A5 12 DE with 3 entries queued -> all outputs return to reset values immediately. After release, a fresh good packet is the only entry.

Source files
------------

// File: rtl/hedios_packet_assembler.sv
// Receive-side framing for the Hedios link: finds SYNC-delimited packets in the
// UART byte stream, verifies their XOR checksum and queues them in a FWFT buffer.
module hedios_packet_assembler #(
   parameter int          QUEUE_DEPTH    = 8,
   parameter int          TIMEOUT_CYCLES = 10000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        pop_packet,
   output logic [7:0]  packet_command,
   output logic [31:0] packet_data,
   output logic        queue_empty,
   output logic        queue_full,
   output logic        lost_data,
   input  logic        clear_errors,
   output logic        checksum_error,
   output logic        timeout_error
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(QUEUE_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_D3, S_D2, S_D1, S_D0, S_CSUM} state_t;

   state_t            state_q, state_d, eff_state;
   logic [TMO_W-1:0]  idle_cnt_q;
   logic [7:0]        cmd_q, xor_q;
   logic [31:0]       data_q;
   logic              timeout_hit, push_req, csum_bad;

   logic [39:0]       mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   // A byte arriving on the timeout cycle is judged as if the FSM were already idle.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      push_req    = 1'b0;
      csum_bad    = 1'b0;
      timeout_hit = (state_q != S_IDLE) && (idle_cnt_q == TMO_LIMIT);
      eff_state   = timeout_hit ? S_IDLE : state_q;
      if (timeout_hit) state_d = S_IDLE;
      if (byte_valid) begin
         case (eff_state)
            S_IDLE: if (byte_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD:  state_d = S_D3;
            S_D3:   state_d = S_D2;
            S_D2:   state_d = S_D1;
            S_D1:   state_d = S_D0;
            S_D0:   state_d = S_CSUM;
            S_CSUM: begin
               state_d = S_IDLE;
               if (byte_data == xor_q) push_req = 1'b1;
               else                    csum_bad = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         idle_cnt_q     <= '0;
         cmd_q          <= '0;
         data_q         <= '0;
         xor_q          <= '0;
         checksum_error <= 1'b0;
         timeout_error  <= 1'b0;
      end else begin
         state_q        <= state_d;
         idle_cnt_q     <= (state_d == S_IDLE || byte_valid) ? '0 : idle_cnt_q + TMO_W'(1);
         checksum_error <= csum_bad;
         timeout_error  <= timeout_hit;
         if (byte_valid) begin
            case (eff_state)
               S_CMD: begin cmd_q <= byte_data; xor_q <= byte_data; end
               S_D3:  begin data_q[31:24] <= byte_data; xor_q <= xor_q ^ byte_data; end
               S_D2:  begin data_q[23:16] <= byte_data; xor_q <= xor_q ^ byte_data; end
               S_D1:  begin data_q[15:8]  <= byte_data; xor_q <= xor_q ^ byte_data; end
               S_D0:  begin data_q[7:0]   <= byte_data; xor_q <= xor_q ^ byte_data; end
               default: ;
            endcase
         end
      end
   end

   // A full queue still accepts a packet when the head is popped in the same cycle.
   assign do_pop  = pop_packet && !queue_empty;
   assign do_push = push_req && (!queue_full || do_pop);

   always_comb begin
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // NOTE: the storage array has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= {cmd_q, data_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         queue_empty    <= 1'b1;
         queue_full     <= 1'b0;
         lost_data      <= 1'b0;
         packet_command <= '0;
         packet_data    <= '0;
      end else begin
         count_q     <= count_d;
         queue_empty <= (count_d == '0);
         queue_full  <= (count_d == DEPTH);
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

         if (push_req && queue_full && !do_pop) lost_data <= 1'b1;
         else if (clear_errors)                 lost_data <= 1'b0;

         // Head register: next stored entry on pop, or the incoming packet when it becomes the head.
         if (do_pop && count_q > CNT_W'(1))
            {packet_command, packet_data} <= mem[rd_ptr_q + PTR_W'(1)];
         else if (do_push && (count_q == '0 || do_pop))
            {packet_command, packet_data} <= {cmd_q, data_q};
      end
   end

endmodule

// File: tb/tb_hedios_packet_assembler.sv
// Directed bench for hedios_packet_assembler: packet table plus timeout,
// overflow, full push/pop and mid-packet reset sequences.
module tb_hedios_packet_assembler;

   localparam int TMO   = 40;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        pop_packet = 1'b0;
   logic        clear_errors = 1'b0;
   logic [7:0]  packet_command;
   logic [31:0] packet_data;
   logic        queue_empty, queue_full, lost_data, checksum_error, timeout_error;

   int n_chk = 0;
   int n_err = 0;

   hedios_packet_assembler #(
      .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .pop_packet(pop_packet), .packet_command(packet_command), .packet_data(packet_data),
      .queue_empty(queue_empty), .queue_full(queue_full), .lost_data(lost_data),
      .clear_errors(clear_errors), .checksum_error(checksum_error), .timeout_error(timeout_error)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
      bit          bad;
      logic        exp_empty;
      logic [7:0]  exp_cmd;
      logic [31:0] exp_data;
      logic        exp_cserr;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] csum_of(input logic [7:0] c, input logic [31:0] d);
      return c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
   endfunction

   // Called at a negedge; the byte is consumed at the next posedge, returns at the following negedge.
   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] cmd, input logic [31:0] data, input bit bad,
                              input int gap, input bit pop_at_csum);
      logic [7:0] bytes [7];
      bytes[0] = 8'hA5;
      bytes[1] = cmd;
      bytes[2] = data[31:24];
      bytes[3] = data[23:16];
      bytes[4] = data[15:8];
      bytes[5] = data[7:0];
      bytes[6] = csum_of(cmd, data) ^ (bad ? 8'h01 : 8'h00);
      for (int i = 0; i < 7; i++) begin
         if (i == 6 && pop_at_csum) pop_packet = 1'b1;
         send_byte(bytes[i]);
         pop_packet = 1'b0;
         if (i < 6) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic pop_once();
      pop_packet = 1'b1;
      @(negedge clk);
      pop_packet = 1'b0;
   endtask

   initial begin
      int pulses;
      int at_k;

      vecs[0] = '{8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{8'h12, 32'hDEADBEEF, 1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 1'b1};
      vecs[2] = '{8'hA5, 32'h00A5A5A5, 1'b0, 1'b0, 8'hA5, 32'h00A5A5A5, 1'b0};
      vecs[3] = '{8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0};
      vecs[4] = '{8'hFF, 32'h12345678, 1'b1, 1'b1, 8'h00, 32'h00000000, 1'b1};
      vecs[5] = '{8'h3C, 32'hA5000001, 1'b0, 1'b0, 8'h3C, 32'hA5000001, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_empty", queue_empty, 1);
      check("rst_full", queue_full, 0);
      check("rst_lost", lost_data, 0);
      check("rst_cserr", checksum_error, 0);
      check("rst_tmo", timeout_error, 0);
      check("rst_cmd", packet_command, 0);
      check("rst_data", packet_data, 0);
      rst = 1'b1;
      @(negedge clk);

      // Non-sync bytes while idle are ignored
      send_byte(8'h00);
      send_byte(8'h12);
      check("idle_noise_empty", queue_empty, 1);

      // Table-driven packets
      for (int i = 0; i < 6; i++) begin
         send_packet(vecs[i].cmd, vecs[i].data, vecs[i].bad, (i == 0) ? 9 : (i % 3), 1'b0);
         check($sformatf("v%0d_empty", i), queue_empty, vecs[i].exp_empty);
         check($sformatf("v%0d_cmd", i), packet_command, vecs[i].exp_cmd);
         check($sformatf("v%0d_data", i), packet_data, vecs[i].exp_data);
         check($sformatf("v%0d_cserr", i), checksum_error, vecs[i].exp_cserr);
         @(negedge clk);
         check($sformatf("v%0d_cserr_off", i), checksum_error, 0);
         if (!vecs[i].exp_empty) begin
            pop_once();
            check($sformatf("v%0d_pop_empty", i), queue_empty, 1);
         end
      end

      // Pop on empty queue is harmless
      pop_once();
      check("pop_empty_empty", queue_empty, 1);
      check("pop_empty_lost", lost_data, 0);

      // Timeout after a partial packet
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'hDE);
      pulses = 0;
      at_k   = 0;
      for (int k = 1; k <= TMO + 5; k++) begin
         @(negedge clk);
         if (timeout_error) begin
            pulses++;
            at_k = k;
         end
      end
      check("tmo_pulses", pulses, 1);
      check("tmo_cycle", at_k, TMO + 1);
      send_packet(8'h12, 32'hDEADBEEF, 1'b0, 0, 1'b0);
      check("tmo_after_empty", queue_empty, 0);
      check("tmo_after_cmd", packet_command, 8'h12);
      check("tmo_after_data", packet_data, 32'hDEADBEEF);
      pop_once();

      // Sync byte landing exactly on the timeout cycle starts a new packet
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'hDE);
      repeat (TMO) @(negedge clk);
      check("tmo_edge_pre", timeout_error, 0);
      send_byte(8'hA5);
      check("tmo_edge_pulse", timeout_error, 1);
      send_byte(8'h77); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(csum_of(8'h77, 32'h01020304));
      check("tmo_edge_empty", queue_empty, 0);
      check("tmo_edge_cmd", packet_command, 8'h77);
      check("tmo_edge_data", packet_data, 32'h01020304);
      pop_once();

      // Overflow: nine packets, no pops
      for (int i = 0; i < 9; i++) begin
         send_packet(8'(i + 1), 32'h10000000 + i, 1'b0, 0, 1'b0);
         if (i == 6) check("ovf_full_at7", queue_full, 0);
         if (i == 7) begin
            check("ovf_full_at8", queue_full, 1);
            check("ovf_lost_at8", lost_data, 0);
         end
      end
      check("ovf_lost_at9", lost_data, 1);
      check("ovf_full_at9", queue_full, 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovf_cmd%0d", i), packet_command, 8'(i + 1));
         check($sformatf("ovf_data%0d", i), packet_data, 32'h10000000 + i);
         pop_once();
      end
      check("ovf_drained", queue_empty, 1);
      check("ovf_lost_sticky", lost_data, 1);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      check("ovf_lost_cleared", lost_data, 0);

      // Full queue with pop coinciding with the CSUM byte
      for (int i = 0; i < 8; i++) send_packet(8'h20 + 8'(i), 32'hC0DE0000 + i, 1'b0, 0, 1'b0);
      check("fpp_full_before", queue_full, 1);
      send_packet(8'h28, 32'hC0DE0008, 1'b0, 0, 1'b1);
      check("fpp_lost", lost_data, 0);
      check("fpp_full", queue_full, 1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("fpp_cmd%0d", i), packet_command, 8'h20 + 8'(i));
         check($sformatf("fpp_data%0d", i), packet_data, 32'hC0DE0000 + i);
         pop_once();
      end
      check("fpp_drained", queue_empty, 1);

      // Asynchronous reset mid-packet with entries queued
      for (int i = 0; i < 3; i++) send_packet(8'h40 + 8'(i), 32'hFACE0000 + i, 1'b0, 0, 1'b0);
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'hDE);
      check("mrst_pre_empty", queue_empty, 0);
      #2 rst = 1'b0;
      #1;
      check("mrst_empty", queue_empty, 1);
      check("mrst_full", queue_full, 0);
      check("mrst_cmd", packet_command, 0);
      check("mrst_data", packet_data, 0);
      check("mrst_tmo", timeout_error, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h30);
      check("mrst_tail_ignored", queue_empty, 1);
      send_packet(8'h55, 32'h11223344, 1'b0, 1, 1'b0);
      check("mrst_new_cmd", packet_command, 8'h55);
      check("mrst_new_data", packet_data, 32'h11223344);
      pop_once();
      check("mrst_only_entry", queue_empty, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
